// File: rtl/vga_scanout_pkg.sv
// Shared VGA definitions: pixel colour type, default 640x480@60 timing
// constants, and the raster phase enum used by both axis counters.
package vga_scanout_pkg;

    localparam int unsigned CNT_W = 10;   // raster counter width (both axes)

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vga_color_t;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } vga_phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Ports:
//   gclk, grst_n : clock, asynchronous active-low reset
//   en           : advance counter and phase this clock
//   cnt          : position 0..TOTAL-1
//   phase        : current phase of the axis
//   wrap         : en while cnt is at TOTAL-1 (counter returns to 0 next clock)
module vga_axis_counter
    import vga_scanout_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output vga_phase_e       phase,
    output logic             wrap
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] END_ACT   = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] END_FRONT = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] END_SYNC  = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] END_ALL   = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_nxt;
    vga_phase_e       phase_nxt;

    assign wrap = en && (cnt == END_ALL);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            cnt   <= '0;
            phase <= PH_ACTIVE;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
        end
    end

    // Phase changes on the last count of the current phase, so the new
    // phase lines up with the first count of the next region.
    always_comb begin
        cnt_nxt   = cnt;
        phase_nxt = phase;
        if (en) begin
            cnt_nxt = wrap ? '0 : cnt + 1'b1;
            unique case (phase)
                PH_ACTIVE: if (cnt == END_ACT)   phase_nxt = PH_FRONT;
                PH_FRONT:  if (cnt == END_FRONT) phase_nxt = PH_SYNC;
                PH_SYNC:   if (cnt == END_SYNC)  phase_nxt = PH_BACK;
                PH_BACK:   if (cnt == END_ALL)   phase_nxt = PH_ACTIVE;
                default:                         phase_nxt = PH_ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA raster timing generator and pin stage (pixel clock domain only).
// Ports:
//   i_vga_clk, i_rst_n : pixel clock, asynchronous active-low reset
//   i_color            : frame-store colour for the address sent READ_LAT clocks ago
//   o_pxlX, o_pxlY     : down-scaled frame-store address (counters >> SCALE_SHIFT)
//   o_color            : registered pin colour, zero while blanked
//   o_hsync, o_vsync   : active-low syncs, aligned with o_color
//   o_vblank           : counter stage is in a non-visible line
//   o_frameStart       : one-clock pulse while counters read (0,0)
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned H_FP        = H_FP_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BP        = H_BP_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned V_FP        = V_FP_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BP        = V_BP_DEF,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic       i_vga_clk,
    input  logic       i_rst_n,
    input  vga_color_t i_color,
    output logic [7:0] o_pxlX,
    output logic [7:0] o_pxlY,
    output vga_color_t o_color,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_vblank,
    output logic       o_frameStart
);

    logic             run;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    vga_phase_e       h_phase, v_phase;
    logic             h_wrap, v_wrap;

    logic vis_raw, hs_raw, vs_raw;
    logic [READ_LAT-1:0] vis_pipe, hs_pipe, vs_pipe;

    // Counters hold (0,0) for the first edge after reset release so that
    // (0,0) is seen for one full clock with o_frameStart high.
    always_ff @(posedge i_vga_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run          <= 1'b0;
            o_frameStart <= 1'b0;
        end else begin
            run          <= 1'b1;
            o_frameStart <= !run || (h_wrap && v_wrap);
        end
    end

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .gclk(i_vga_clk), .grst_n(i_rst_n), .en(run),
        .cnt(h_cnt), .phase(h_phase), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .gclk(i_vga_clk), .grst_n(i_rst_n), .en(h_wrap),
        .cnt(v_cnt), .phase(v_phase), .wrap(v_wrap)
    );

    assign o_pxlX   = 8'(h_cnt >> SCALE_SHIFT);
    assign o_pxlY   = 8'(v_cnt >> SCALE_SHIFT);
    assign o_vblank = (v_cnt >= CNT_W'(V_ACTIVE));

    // Gated by run so the held reset state never feeds a pixel into the pipe.
    assign vis_raw = run && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    assign hs_raw  = run && (h_phase == PH_SYNC);
    assign vs_raw  = run && (v_phase == PH_SYNC);

    // Delay line matches the frame-store read latency.
    always_ff @(posedge i_vga_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vis_pipe <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
        end else begin
            vis_pipe[0] <= vis_raw;
            hs_pipe[0]  <= hs_raw;
            vs_pipe[0]  <= vs_raw;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                vis_pipe[i] <= vis_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
            end
        end
    end

    always_ff @(posedge i_vga_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_color <= '0;
            o_hsync <= 1'b1;
            o_vsync <= 1'b1;
        end else begin
            o_color <= vis_pipe[READ_LAT-1] ? i_color : '0;
            o_hsync <= ~hs_pipe[READ_LAT-1];
            o_vsync <= ~vs_pipe[READ_LAT-1];
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;
    import vga_scanout_pkg::*;

    // Reduced raster for the small instances: 24 clocks/line, 15 lines/frame.
    localparam int HT = 24;
    localparam int VT = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_color_t col_d, col_1, col_3;
    logic [7:0] x_d, y_d, x_1, y_1, x_3, y_3;
    vga_color_t oc_d, oc_1, oc_3;
    logic hs_d, vs_d, vb_d, fs_d;
    logic hs_1, vs_1, vb_1, fs_1;
    logic hs_3, vs_3, vb_3, fs_3;

    int checks = 0;
    int errors = 0;
    logic [15:0] hist1 [0:3];
    logic [15:0] hist3 [0:3];
    int nz_cnt, low_cnt, first_fall;

    vga_scanout dut_d (
        .i_vga_clk(clk), .i_rst_n(rst_n), .i_color(col_d),
        .o_pxlX(x_d), .o_pxlY(y_d), .o_color(oc_d), .o_hsync(hs_d),
        .o_vsync(vs_d), .o_vblank(vb_d), .o_frameStart(fs_d)
    );

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SCALE_SHIFT(2), .READ_LAT(1)
    ) dut_s1 (
        .i_vga_clk(clk), .i_rst_n(rst_n), .i_color(col_1),
        .o_pxlX(x_1), .o_pxlY(y_1), .o_color(oc_1), .o_hsync(hs_1),
        .o_vsync(vs_1), .o_vblank(vb_1), .o_frameStart(fs_1)
    );

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SCALE_SHIFT(2), .READ_LAT(3)
    ) dut_s3 (
        .i_vga_clk(clk), .i_rst_n(rst_n), .i_color(col_3),
        .o_pxlX(x_3), .o_pxlY(y_3), .o_color(oc_3), .o_hsync(hs_3),
        .o_vsync(vs_3), .o_vblank(vb_3), .o_frameStart(fs_3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vga_color_t pat(input logic [7:0] x, input logic [7:0] y);
        vga_color_t c;
        c.r = x[3:0];
        c.g = y[3:0];
        c.b = x[3:0] + y[3:0];
        return c;
    endfunction

    // Small-raster reference: counters at clock n, pins show clock n-rl-1.
    task automatic chk_small(input string nm, input int rl, input int n,
                             input logic [7:0] px, input logic [7:0] py,
                             input vga_color_t c, input logic hs, input logic vs,
                             input logic vb, input logic fs);
        int h, v, m, hm, vm;
        vga_color_t ec;
        logic ehs, evs;
        h = n % HT;
        v = (n / HT) % VT;
        m = n - rl - 1;
        ec = '0; ehs = 1'b1; evs = 1'b1;
        if (m >= 0) begin
            hm = m % HT;
            vm = (m / HT) % VT;
            if (hm < 16 && vm < 8) ec = pat(8'(hm >> 2), 8'(vm >> 2));
            ehs = !(hm >= 18 && hm < 22);
            evs = !(vm >= 10 && vm < 12);
        end
        chk({nm, "_pxlX"}, 32'(px), 32'(h >> 2));
        chk({nm, "_pxlY"}, 32'(py), 32'(v >> 2));
        chk({nm, "_frameStart"}, 32'(fs), 32'(h == 0 && v == 0));
        chk({nm, "_vblank"}, 32'(vb), 32'(v >= 8));
        chk({nm, "_color"}, 32'(c), 32'(ec));
        chk({nm, "_hsync"}, 32'(hs), 32'(ehs));
        chk({nm, "_vsync"}, 32'(vs), 32'(evs));
    endtask

    // Default 800x525 raster, READ_LAT=1, i_color all ones.
    task automatic chk_def(input int n);
        int h, v, m, hm, vm;
        logic ehs, evis;
        h = n % 800;
        v = (n / 800) % 525;
        m = n - 2;
        ehs = 1'b1; evis = 1'b0;
        if (m >= 0) begin
            hm = m % 800;
            vm = (m / 800) % 525;
            ehs = !(hm >= 656 && hm < 752);
            evis = (hm < 640 && vm < 480);
        end
        chk("def_pxlX", 32'(x_d), 32'((h >> 2) & 255));
        chk("def_pxlY", 32'(y_d), 32'((v >> 2) & 255));
        chk("def_frameStart", 32'(fs_d), 32'(n == 0));
        chk("def_vblank", 32'(vb_d), 32'(v >= 480));
        chk("def_hsync", 32'(hs_d), 32'(ehs));
        chk("def_color", 32'(oc_d), evis ? 32'h fff : 32'h0);
    endtask

    task automatic chk_rst(input string nm, input logic [7:0] px, input logic [7:0] py,
                           input vga_color_t c, input logic hs, input logic vs,
                           input logic vb, input logic fs);
        chk({nm, "_rst_pxl"}, 32'({px, py}), 32'h0);
        chk({nm, "_rst_color"}, 32'(c), 32'h0);
        chk({nm, "_rst_sync"}, 32'({hs, vs}), 32'h3);
        chk({nm, "_rst_vb_fs"}, 32'({vb, fs}), 32'h0);
    endtask

    task automatic chk_all_rst();
        chk_rst("d",  x_d, y_d, oc_d, hs_d, vs_d, vb_d, fs_d);
        chk_rst("s1", x_1, y_1, oc_1, hs_1, vs_1, vb_1, fs_1);
        chk_rst("s3", x_3, y_3, oc_3, hs_3, vs_3, vb_3, fs_3);
    endtask

    // One clock: check at the negedge, then feed the frame-store model.
    task automatic cycle(input int n);
        @(negedge clk);
        chk_small("s1", 1, n, x_1, y_1, oc_1, hs_1, vs_1, vb_1, fs_1);
        chk_small("s3", 3, n, x_3, y_3, oc_3, hs_3, vs_3, vb_3, fs_3);
        chk_def(n);
        for (int i = 3; i > 0; i--) begin
            hist1[i] = hist1[i-1];
            hist3[i] = hist3[i-1];
        end
        hist1[0] = {y_1, x_1};
        hist3[0] = {y_3, x_3};
        col_1 = pat(hist1[1][7:0], hist1[1][15:8]);
        col_3 = pat(hist3[3][7:0], hist3[3][15:8]);
    endtask

    initial begin
        rst_n = 1'b0;
        col_d = '1;
        col_1 = '0;
        col_3 = '0;
        for (int i = 0; i < 4; i++) begin
            hist1[i] = '0;
            hist3[i] = '0;
        end
        nz_cnt = 0; low_cnt = 0; first_fall = -1;

        repeat (3) @(negedge clk);
        chk_all_rst();
        rst_n = 1'b1;

        // Several small frames and the first two default lines.
        for (int n = 0; n <= 1582; n++) begin
            cycle(n);
            if (n >= 2 && n <= 801) begin
                if (oc_d != '0) nz_cnt++;
                if (!hs_d) begin
                    low_cnt++;
                    if (first_fall < 0) first_fall = n;
                end
            end
            if (n == 801) begin
                chk("def_line_nonzero", 32'(nz_cnt), 32'd640);
                chk("def_line_hs_low", 32'(low_cnt), 32'd96);
                chk("def_hs_fall", 32'(first_fall), 32'd658);
            end
        end

        // Mid-frame reset while the small instances drive hsync low.
        rst_n = 1'b0;
        #1;
        chk_all_rst();
        repeat (3) begin
            @(negedge clk);
            chk_all_rst();
        end
        rst_n = 1'b1;

        for (int n = 0; n < 800; n++) cycle(n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
